// File: rtl/cabac_byte_feeder.sv
// Bit-position sequencer and byte arbiter for the VVC CABAC value/range engine.
// Define CABAC_BYTE_PREFETCH_EN to add a one-byte holding buffer that hides refill stalls.
module cabac_byte_feeder #(
  parameter int INIT_BYTES = 3,
  parameter int CNT_W      = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start,
  input  logic [7:0]              bs_data,
  input  logic                    bs_valid,
  output logic                    bs_ready,
  input  logic                    dec_valid,
  output logic                    dec_ready,
  input  logic                    dec_bypass,
  input  logic [2:0]              dec_numBits,
  input  logic [1:0]              dec_nBin,
  input  logic                    dec_mps_lps,
  input  logic                    dec_mps_renorm,
  output logic [7:0]              byte_out,
  output logic                    byte_load,
  output logic signed [3:0]       bits_needed,
  output logic signed [3:0]       bits_needed_rb,
  output logic                    init_done,
  output logic [CNT_W-1:0]        bytes_consumed
);

  typedef enum logic [1:0] {IDLE, INIT, RUN, REFILL} state_t;

  localparam logic signed [3:0] BN_INIT = 4'sb1000;

  state_t            state;
  logic              step_hs;
  logic              bs_hs;
  logic              renorm;
  logic [2:0]        amt;
  logic signed [3:0] sum;
  logic              request;
  logic signed [3:0] bn_next;

`ifdef CABAC_BYTE_PREFETCH_EN
  logic       buf_valid;
  logic [7:0] buf_data;
  logic       use_buf;
`endif

  assign step_hs = dec_valid & dec_ready;
  assign bs_hs   = bs_valid & bs_ready;

  // Sum stays within [-8,6], so 4-bit signed arithmetic never overflows.
  always_comb begin
    renorm  = dec_bypass | dec_mps_lps | dec_mps_renorm;
    amt     = dec_bypass ? dec_numBits : {1'b0, dec_nBin} + 3'd1;
    sum     = renorm ? bits_needed + $signed({1'b0, amt}) : bits_needed;
    request = renorm & ~sum[3];
    bn_next = request ? sum + BN_INIT : sum;
  end

  // NOTE: every output gets a default first so no path leaves a latch.
  always_comb begin
    dec_ready = 1'b0;
    bs_ready  = 1'b0;
    byte_load = 1'b0;
    byte_out  = 8'h00;
`ifdef CABAC_BYTE_PREFETCH_EN
    use_buf   = 1'b0;
`endif
    if (!start) begin
      case (state)
        INIT:   bs_ready = 1'b1;
        RUN: begin
          dec_ready = 1'b1;
`ifdef CABAC_BYTE_PREFETCH_EN
          bs_ready  = ~buf_valid;
`endif
        end
        REFILL: bs_ready = 1'b1;
        default: ;
      endcase
    end
    if (bs_hs && (state == INIT || state == REFILL)) begin
      byte_load = 1'b1;
      byte_out  = bs_data;
    end
`ifdef CABAC_BYTE_PREFETCH_EN
    // A byte arriving alongside a requesting step is handed straight through.
    if (state == RUN && step_hs && request) begin
      if (buf_valid) begin
        byte_load = 1'b1;
        byte_out  = buf_data;
        use_buf   = 1'b1;
      end else if (bs_hs) begin
        byte_load = 1'b1;
        byte_out  = bs_data;
      end
    end
`endif
  end

  // NOTE: sequential state uses non-blocking assignments only, so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= IDLE;
      bits_needed    <= BN_INIT;
      bits_needed_rb <= 4'sd0;
      init_done      <= 1'b0;
      bytes_consumed <= '0;
    end else begin
      init_done <= 1'b0;
      if (byte_load && bytes_consumed != '1)
        bytes_consumed <= bytes_consumed + 1'b1;
      if (start) begin
        state          <= INIT;
        bits_needed    <= BN_INIT;
        bytes_consumed <= '0;
      end else begin
        case (state)
          INIT: begin
            if (bs_hs && bytes_consumed == CNT_W'(INIT_BYTES - 1)) begin
              state     <= RUN;
              init_done <= 1'b1;
            end
          end
          RUN: begin
            if (step_hs) begin
              bits_needed    <= bn_next;
              bits_needed_rb <= sum;
`ifdef CABAC_BYTE_PREFETCH_EN
              if (request && !buf_valid && !bs_hs) state <= REFILL;
`else
              if (request) state <= REFILL;
`endif
            end
          end
          REFILL: begin
            if (bs_hs) state <= RUN;
          end
          default: ;
        endcase
      end
    end
  end

`ifdef CABAC_BYTE_PREFETCH_EN
  // NOTE: buf_data needs no reset; buf_valid alone qualifies it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      buf_valid <= 1'b0;
    end else if (start) begin
      buf_valid <= 1'b0;
    end else if (use_buf) begin
      buf_valid <= 1'b0;
    end else if (state == RUN && bs_hs && !(step_hs && request)) begin
      buf_valid <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (state == RUN && bs_hs) buf_data <= bs_data;
  end
`endif

endmodule

// File: tb/tb_cabac_byte_feeder.sv
// Self-checking bench for cabac_byte_feeder: directed cases plus random steps against an arithmetic model.
module tb_cabac_byte_feeder;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              start = 1'b0;
  logic [7:0]        bs_data = 8'h00;
  logic              bs_valid = 1'b0;
  logic              dec_valid = 1'b0;
  logic              dec_bypass = 1'b0;
  logic [2:0]        dec_numBits = 3'd0;
  logic [1:0]        dec_nBin = 2'd0;
  logic              dec_mps_lps = 1'b0;
  logic              dec_mps_renorm = 1'b0;

  logic              bs_ready, dec_ready, byte_load, init_done;
  logic [7:0]        byte_out;
  logic signed [3:0] bits_needed, bits_needed_rb;
  logic [15:0]       bytes_consumed;

  logic              s_bs_ready, s_dec_ready, s_byte_load, s_init_done;
  logic [7:0]        s_byte_out;
  logic signed [3:0] s_bits_needed, s_bits_needed_rb;
  logic [2:0]        s_bytes_consumed;

  cabac_byte_feeder #(.INIT_BYTES(3), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .bs_data(bs_data), .bs_valid(bs_valid), .bs_ready(bs_ready),
    .dec_valid(dec_valid), .dec_ready(dec_ready),
    .dec_bypass(dec_bypass), .dec_numBits(dec_numBits), .dec_nBin(dec_nBin),
    .dec_mps_lps(dec_mps_lps), .dec_mps_renorm(dec_mps_renorm),
    .byte_out(byte_out), .byte_load(byte_load),
    .bits_needed(bits_needed), .bits_needed_rb(bits_needed_rb),
    .init_done(init_done), .bytes_consumed(bytes_consumed)
  );

  // Narrow-counter copy sharing the same stimulus, used to observe saturation.
  cabac_byte_feeder #(.INIT_BYTES(3), .CNT_W(3)) dut_sat (
    .clk(clk), .rst_n(rst_n), .start(start),
    .bs_data(bs_data), .bs_valid(bs_valid), .bs_ready(s_bs_ready),
    .dec_valid(dec_valid), .dec_ready(s_dec_ready),
    .dec_bypass(dec_bypass), .dec_numBits(dec_numBits), .dec_nBin(dec_nBin),
    .dec_mps_lps(dec_mps_lps), .dec_mps_renorm(dec_mps_renorm),
    .byte_out(s_byte_out), .byte_load(s_byte_load),
    .bits_needed(s_bits_needed), .bits_needed_rb(s_bits_needed_rb),
    .init_done(s_init_done), .bytes_consumed(s_bytes_consumed)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  int total = 0;
  int bad = 0;
  int m_bn;
  int m_cnt;
  int refill_low;
  int refill_loads;

  task automatic check(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic int sat7(input int n);
    return (n > 7) ? 7 : n;
  endfunction

  task automatic check_reset_outputs(input string tag);
    check({tag, "_bs_ready"}, bs_ready, 0);
    check({tag, "_dec_ready"}, dec_ready, 0);
    check({tag, "_byte_load"}, byte_load, 0);
    check({tag, "_byte_out"}, byte_out, 0);
    check({tag, "_bits_needed"}, bits_needed, -8);
    check({tag, "_bits_needed_rb"}, bits_needed_rb, 0);
    check({tag, "_init_done"}, init_done, 0);
    check({tag, "_bytes_consumed"}, bytes_consumed, 0);
  endtask

  // Slice start: model counters are cleared and the position restarts at -8.
  task automatic init_seq(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2);
    logic [7:0] bytes [3];
    bytes[0] = b0; bytes[1] = b1; bytes[2] = b2;
    start = 1'b1;
    #1;
    check("start_bs_ready", bs_ready, 0);
    check("start_dec_ready", dec_ready, 0);
    tick();
    start = 1'b0;
    m_bn = -8;
    m_cnt = 0;
    check("init_bn", bits_needed, -8);
    check("init_cnt", bytes_consumed, 0);
    for (int i = 0; i < 3; i++) begin
      bs_valid = 1'b1;
      bs_data = bytes[i];
      #1;
      check("init_bs_ready", bs_ready, 1);
      check("init_load", byte_load, 1);
      check("init_byte", byte_out, bytes[i]);
      check("init_done_early", init_done, 0);
      m_cnt++;
      tick();
    end
    bs_valid = 1'b0;
    check("init_done_pulse", init_done, 1);
    check("init_bn_after", bits_needed, -8);
    check("init_cnt_after", bytes_consumed, 3);
    #1;
    check("run_dec_ready", dec_ready, 1);
    tick();
    check("init_done_clear", init_done, 0);
  endtask

  // Reference rule: sum = position + bits consumed; a non-negative sum costs one byte.
  task automatic model_step(input bit byp, input int nb, input int nbin, input bit lps, input bit ren,
                            output bit req, output int rb);
    int s;
    if (!(byp || lps || ren)) begin
      rb = m_bn;
      req = 1'b0;
    end else begin
      s = m_bn + (byp ? nb : nbin + 1);
      rb = s;
      req = (s >= 0);
      m_bn = req ? s - 8 : s;
    end
  endtask

  task automatic do_step(input bit byp, input int nb, input int nbin, input bit lps, input bit ren,
                         input bit noise, output bit req);
    int rb;
    dec_valid = 1'b1;
    dec_bypass = byp;
    dec_numBits = nb[2:0];
    dec_nBin = nbin[1:0];
    dec_mps_lps = lps;
    dec_mps_renorm = ren;
    bs_valid = noise;
    bs_data = 8'($urandom);
    #1;
    check("step_ready", dec_ready, 1);
    check("step_no_load", byte_load, 0);
    model_step(byp, nb, nbin, lps, ren, req, rb);
    tick();
    dec_valid = 1'b0;
    bs_valid = 1'b0;
    check("step_bn", bits_needed, m_bn);
    check("step_rb", bits_needed_rb, rb);
    #1;
    check("step_next_ready", dec_ready, req ? 0 : 1);
  endtask

  task automatic refill(input int waits, input logic [7:0] data);
    for (int i = 0; i < waits; i++) begin
      bs_valid = 1'b0;
      #1;
      check("refill_stall", dec_ready, 0);
      check("refill_no_load", byte_load, 0);
      check("refill_bn_hold", bits_needed, m_bn);
      if (!dec_ready) refill_low++;
      tick();
    end
    bs_valid = 1'b1;
    bs_data = data;
    #1;
    check("refill_hs_ready", dec_ready, 0);
    check("refill_load", byte_load, 1);
    check("refill_byte", byte_out, data);
    if (!dec_ready) refill_low++;
    if (byte_load) refill_loads++;
    m_cnt++;
    tick();
    bs_valid = 1'b0;
    check("refill_cnt", bytes_consumed, m_cnt);
    check("refill_cnt_sat", s_bytes_consumed, sat7(m_cnt));
    #1;
    check("refill_back_run", dec_ready, 1);
  endtask

  initial begin
    bit req;
    bit noise;

    // Reset state.
    tick();
    check_reset_outputs("rst");
    rst_n = 1'b1;
    tick();
    check("idle_dec_ready", dec_ready, 0);
    check("idle_bs_ready", bs_ready, 0);

    init_seq(8'h12, 8'h34, 8'h56);

    // Bypass steps: -8 +7 -> -1, then -1 +2 -> 1 -> -7 with a refill.
    do_step(1, 7, 0, 0, 0, 0, req);
    check("t2_no_load", byte_load, 0);
    do_step(1, 2, 0, 0, 0, 0, req);
    check("t2_rb_one", bits_needed_rb, 1);
    check("t2_bn_m7", bits_needed, -7);
    refill(0, 8'hAB);

    // Regular renormalising and non-renormalising steps.
    do_step(1, 5, 0, 0, 0, 0, req);
    check("t3_bn_m2", bits_needed, -2);
    do_step(0, 0, 2, 0, 1, 0, req);
    check("t3_bn_m7", bits_needed, -7);
    refill(1, 8'h3C);
    do_step(1, 2, 0, 0, 0, 0, req);
    do_step(0, 0, 1, 0, 0, 0, req);
    check("t3_hold_m5", bits_needed, -5);

    // Slow byte source during refill.
    do_step(1, 5, 0, 0, 0, 0, req);
    refill_low = 0;
    refill_loads = 0;
    refill(4, 8'h5A);
    check("t4_low_cycles", refill_low, 5);
    check("t4_loads", refill_loads, 1);

    // Random steps against the model.
    for (int n = 0; n < 200; n++) begin
`ifdef CABAC_BYTE_PREFETCH_EN
      noise = 1'b0;
`else
      noise = 1'($urandom_range(0, 1));
`endif
      do_step(1'($urandom_range(0, 1)), int'($urandom_range(0, 7)), int'($urandom_range(0, 3)),
              1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), noise, req);
      if (req) refill(int'($urandom_range(0, 3)), 8'($urandom));
    end
    check("sat_cnt", s_bytes_consumed, 7);

    // Abort during refill with a byte on offer.
    do_step(1, 7, 0, 0, 0, 0, req);
    if (!req) do_step(1, 7, 0, 0, 0, 0, req);
    start = 1'b1;
    bs_valid = 1'b1;
    bs_data = 8'hEE;
    #1;
    check("abort_no_load", byte_load, 0);
    check("abort_bs_ready", bs_ready, 0);
    check("abort_dec_ready", dec_ready, 0);
    tick();
    start = 1'b0;
    bs_valid = 1'b0;
    check("abort_bn", bits_needed, -8);
    check("abort_cnt", bytes_consumed, 0);
    check("abort_cnt_sat", s_bytes_consumed, 0);
    #1;
    check("abort_in_init", bs_ready, 1);
    bs_valid = 1'b1;
    bs_data = 8'h77;
    #1;
    check("abort_init_load", byte_out, 8'h77);
    tick();
    bs_valid = 1'b0;
    check("abort_init_cnt", bytes_consumed, 1);

    // Asynchronous reset mid-initialisation.
    #2;
    rst_n = 1'b0;
    #1;
    check_reset_outputs("async_rst");
    tick();
    rst_n = 1'b1;
    tick();

`ifdef CABAC_BYTE_PREFETCH_EN
    // Prefetched byte serves a requesting step with no stall.
    init_seq(8'h01, 8'h02, 8'h03);
    bs_valid = 1'b1;
    bs_data = 8'hCD;
    #1;
    check("pf_fill_ready", bs_ready, 1);
    check("pf_fill_no_load", byte_load, 0);
    tick();
    bs_valid = 1'b0;
    #1;
    check("pf_full_ready", bs_ready, 0);
    do_step(1, 7, 0, 0, 0, 0, req);
    dec_valid = 1'b1;
    dec_bypass = 1'b1;
    dec_numBits = 3'd2;
    #1;
    check("pf_load", byte_load, 1);
    check("pf_byte", byte_out, 8'hCD);
    tick();
    dec_valid = 1'b0;
    check("pf_bn", bits_needed, -7);
    #1;
    check("pf_no_stall", dec_ready, 1);
    check("pf_empty_ready", bs_ready, 1);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
